// File: rtl/sync_counter_pkg.sv
// sync_counter_pkg: shared state encoding, lane count and saturating increment for the lane checker.
package sync_counter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, CHECK = 2'd2, FAULT = 2'd3} state_e;
  localparam int NUM_LANES = 4;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/sync_counter_checker_lane.sv
// lane_step_check: holds one lane's previous sample and flags step mismatches and wraps.
module lane_step_check import sync_counter_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] q_i,
  output logic             mismatch_o,
  output logic             wrap_o
);
  logic [WIDTH-1:0] prev_q, prev_d, exp_val;
  assign prev_d = load_i ? q_i : prev_q;
  assign exp_val = prev_q + 1'b1;
  assign mismatch_o = q_i != exp_val;
  assign wrap_o = (prev_q == '1) && (q_i == '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) prev_q <= '0;
    else prev_q <= prev_d;
endmodule

// File: rtl/sync_counter_checker.sv
// sync_counter_checker: lockstep monitor for a four-lane counter bus with sticky error reporting.
module sync_counter_checker import sync_counter_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] q0,
  input  logic [WIDTH-1:0] q1,
  input  logic [WIDTH-1:0] q2,
  input  logic [WIDTH-1:0] q3,
  output logic [1:0]       state,
  output logic [3:0]       lane_err,
  output logic [1:0]       first_err_lane,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] wrap_cnt
);
  localparam logic [31:0] ERR_MAX = (32'd1 << ERR_W) - 32'd1;
  state_e state_q, state_d;
  logic [NUM_LANES-1:0] mism, wrap, lane_err_q, lane_err_d;
  logic [1:0] first_q, first_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d, wrap_cnt_q, wrap_cnt_d;
  logic [WIDTH-1:0] q_in [NUM_LANES];
  logic load, chk;
  assign q_in = '{q0, q1, q2, q3};
  genvar i;
  for (i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_step_check #(.WIDTH(WIDTH)) u_lane (
      .clk(clk), .rst(rst), .load_i(load), .q_i(q_in[i]),
      .mismatch_o(mism[i]), .wrap_o(wrap[i])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = !en ? IDLE : clr ? ARM : state_q == IDLE ? ARM : state_q == ARM ? CHECK :
              (state_q == FAULT || |mism) ? FAULT : CHECK;
  end
  always_comb begin
    load = state_q != IDLE;
    chk = en && !clr && (state_q == CHECK || state_q == FAULT);
  end
  // clr wipes the stickies whatever en is; a mismatch seen alongside clr is dropped
  always_comb begin
    lane_err_d = clr ? '0 : chk ? lane_err_q | mism : lane_err_q;
    first_d = clr ? 2'd0 : (chk && state_q == CHECK && |mism) ?
              (mism[0] ? 2'd0 : mism[1] ? 2'd1 : mism[2] ? 2'd2 : 2'd3) : first_q;
    err_cnt_d = clr ? '0 : (chk && |mism) ? ERR_W'(sat_inc(32'(err_cnt_q), ERR_MAX)) : err_cnt_q;
    wrap_cnt_d = clr ? '0 : (chk && wrap[0]) ? ERR_W'(sat_inc(32'(wrap_cnt_q), ERR_MAX)) : wrap_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lane_err_q <= '0;
      first_q <= '0;
      err_cnt_q <= '0;
      wrap_cnt_q <= '0;
    end else begin
      lane_err_q <= lane_err_d;
      first_q <= first_d;
      err_cnt_q <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  assign state = state_q;
  assign lane_err = lane_err_q;
  assign first_err_lane = first_q;
  assign err_cnt = err_cnt_q;
  assign wrap_cnt = wrap_cnt_q;
endmodule

// File: tb/tb_sync_counter_checker.sv
// tb_sync_counter_checker: scoreboard bench driving counter patterns against a behavioural checker model.
module tb_sync_counter_checker;
  logic clk = 1'b0;
  logic rst, en, clr;
  logic [3:0] q0, q1, q2, q3;
  logic [1:0] state, first_err_lane;
  logic [3:0] lane_err;
  logic [7:0] err_cnt, wrap_cnt;
  typedef struct {
    logic [1:0] st;
    logic [3:0] le;
    logic [1:0] fl;
    logic [7:0] ec;
    logic [7:0] wc;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic [1:0] m_st, m_fl;
  logic [3:0] m_le;
  logic [7:0] m_ec, m_wc;
  logic [3:0] m_prev [4];
  logic [3:0] cnt;
  logic [3:0] off [4];
  sync_counter_checker #(.WIDTH(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .state(state), .lane_err(lane_err), .first_err_lane(first_err_lane),
    .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_st = 2'd0; m_fl = 2'd0; m_le = '0; m_ec = '0; m_wc = '0;
    for (int i = 0; i < 4; i++) m_prev[i] = '0;
  endtask
  task automatic step(input logic e, input logic c, input logic [3:0] a0, a1, a2, a3);
    logic [3:0] v [4];
    logic [3:0] mm;
    logic act;
    exp_t x;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    en = e; clr = c; q0 = a0; q1 = a1; q2 = a2; q3 = a3;
    act = e && !c && (m_st == 2'd2 || m_st == 2'd3);
    mm = '0;
    for (int i = 0; i < 4; i++) if (v[i] != 4'(m_prev[i] + 4'd1)) mm[i] = 1'b1;
    if (c) begin
      m_le = '0; m_fl = '0; m_ec = '0; m_wc = '0;
    end else if (act) begin
      if (m_st == 2'd2 && mm != 0) for (int i = 3; i >= 0; i--) if (mm[i]) m_fl = 2'(i);
      m_le |= mm;
      if (mm != 0 && m_ec != 8'hff) m_ec++;
      if (m_prev[0] == 4'hf && v[0] == 4'h0 && m_wc != 8'hff) m_wc++;
    end
    if (m_st != 2'd0) for (int i = 0; i < 4; i++) m_prev[i] = v[i];
    if (!e) m_st = 2'd0;
    else if (c || m_st == 2'd0) m_st = 2'd1;
    else if (m_st == 2'd1) m_st = 2'd2;
    else if (m_st == 2'd2 && mm != 0) m_st = 2'd3;
    sb.push_back('{m_st, m_le, m_fl, m_ec, m_wc});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("state", 32'(state), 32'(x.st));
    check("lane_err", 32'(lane_err), 32'(x.le));
    check("first_err_lane", 32'(first_err_lane), 32'(x.fl));
    check("err_cnt", 32'(err_cnt), 32'(x.ec));
    check("wrap_cnt", 32'(wrap_cnt), 32'(x.wc));
  endtask
  task automatic run(input int n);
    repeat (n) begin
      step(1'b1, 1'b0, cnt + off[0], cnt + off[1], cnt + off[2], cnt + off[3]);
      cnt++;
    end
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; q0 = '0; q1 = '0; q2 = '0; q3 = '0;
    cnt = '0;
    for (int i = 0; i < 4; i++) off[i] = '0;
    model_reset();
    #12;
    check("rst_state", 32'(state), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, 1'b0, 4'd3, 4'd3, 4'd3, 4'd3);
    step(1'b0, 1'b0, 4'd4, 4'd4, 4'd4, 4'd4);
    run(40);
    check("ideal_state", 32'(state), 32'd2);
    check("ideal_wrap", 32'(wrap_cnt), 32'd2);
    check("ideal_err", 32'(err_cnt), 32'd0);
    while (cnt != 4'd5) run(1);
    step(1'b1, 1'b0, cnt, cnt, 4'd9, cnt);
    cnt++;
    run(3);
    check("glitch_state", 32'(state), 32'd3);
    check("glitch_lane_err", 32'(lane_err), 32'h4);
    check("glitch_first", 32'(first_err_lane), 32'd2);
    check("glitch_err", 32'(err_cnt), 32'd2);
    step(1'b1, 1'b1, cnt, cnt, cnt, cnt);
    cnt++;
    run(4);
    off[1] = 4'd1; off[3] = 4'd1;
    run(1);
    check("simul_lane_err", 32'(lane_err), 32'hA);
    check("simul_first", 32'(first_err_lane), 32'd1);
    check("simul_err", 32'(err_cnt), 32'd1);
    run(3);
    off[0] = 4'd1;
    run(2);
    check("late_first", 32'(first_err_lane), 32'd1);
    check("late_lane_err", 32'(lane_err), 32'hB);
    for (int i = 0; i < 4; i++) off[i] = '0;
    step(1'b1, 1'b1, cnt, cnt, cnt, cnt);
    cnt++;
    run(3);
    repeat (300) begin
      step(1'b1, 1'b0, 4'd7, cnt, cnt, cnt);
      cnt++;
    end
    check("sat_err", 32'(err_cnt), 32'd255);
    step(1'b1, 1'b1, 4'd7, cnt, cnt, cnt);
    cnt++;
    check("clr_state", 32'(state), 32'd1);
    check("clr_lane_err", 32'(lane_err), 32'd0);
    check("clr_err", 32'(err_cnt), 32'd0);
    run(5);
    check("resume_state", 32'(state), 32'd2);
    check("resume_err", 32'(err_cnt), 32'd0);
    repeat (5) step(1'b1, 1'b0, cnt - 4'd1, cnt, cnt, cnt);
    check("pre_rst_err", 32'(err_cnt), 32'd5);
    check("pre_rst_state", 32'(state), 32'd3);
    en = 1'b1;
    rst = 1'b1;
    #2;
    check("async_state", 32'(state), 32'd0);
    check("async_lane_err", 32'(lane_err), 32'd0);
    check("async_first", 32'(first_err_lane), 32'd0);
    check("async_err", 32'(err_cnt), 32'd0);
    check("async_wrap", 32'(wrap_cnt), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    run(2);
    check("post_rst_state", 32'(state), 32'd2);
    run(20);
    step(1'b0, 1'b0, cnt, cnt, cnt, cnt);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
